shift_scheduler: RTL and testbench

//   Sequences the P/N/R/D gearbox selector FSM and its shift actuator. Debounces driver

---
 rtl/shift_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_shift_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_scheduler.sv
// shift_scheduler: P/N/R/D selector sequencer with debounced inputs, safety interlocks,
// D1-D4 speed scheduling with hysteresis and a timed req/ack actuator handshake.
// Optional feature: define KICKDOWN_EN to add the kickdown input.

module shift_sched_deb #(
    parameter int DEB_CYC = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic deb_o
);
    localparam int CW = $clog2(DEB_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // cnt_q counts consecutive samples that disagree with the accepted level
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (raw_i != deb_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) deb_d = raw_i;
            else                           cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module shift_scheduler #(
    parameter int SPEED_W   = 8,
    parameter int UP12      = 20,
    parameter int UP23      = 40,
    parameter int UP34      = 60,
    parameter int HYST      = 5,
    parameter int DEB_CYC   = 4,
    parameter int SHIFT_CYC = 255
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               p_i,
    input  logic               n_i,
    input  logic               r_i,
    input  logic               d_i,
    input  logic               brake_i,
    input  logic [SPEED_W-1:0] speed_i,
`ifdef KICKDOWN_EN
    input  logic               kickdown_i,
`endif
    input  logic               act_ack_i,
    output logic               act_req_o,
    output logic [1:0]         act_mode_o,
    output logic [1:0]         act_gear_o,
    output logic [1:0]         mode_o,
    output logic [1:0]         gear_o,
    output logic               busy_o,
    output logic               reject_o,
    output logic               fault_o
);
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_FAULT = 2'd3;
    localparam logic [1:0] M_P = 2'b00, M_N = 2'b01, M_R = 2'b10, M_D = 2'b11;
    localparam int WCW = $clog2(SHIFT_CYC + 1);

    localparam logic [SPEED_W-1:0] T12 = SPEED_W'(UP12);
    localparam logic [SPEED_W-1:0] T23 = SPEED_W'(UP23);
    localparam logic [SPEED_W-1:0] T34 = SPEED_W'(UP34);

    logic [3:0] sel_raw, sel_deb;
    assign sel_raw = {d_i, r_i, n_i, p_i};

    for (genvar i = 0; i < 4; i++) begin : g_deb
        shift_sched_deb #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .raw_i   (sel_raw[i]),
            .deb_o   (sel_deb[i])
        );
    end

    logic           win_vld;
    logic [1:0]     win;
    logic [2:0]     sel_last_q, sel_last_d;
    logic           pend;
    logic [1:0]     state_q, state_d, mode_q, mode_d, gear_q, gear_d;
    logic [1:0]     act_mode_q, act_mode_d, act_gear_q, act_gear_d;
    logic           act_req_q, act_req_d, reject_q, reject_d, fault_q, fault_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [SPEED_W-1:0] up_thr, in_thr;
    logic           up_ok, dn_ok;

    always_comb begin
        win_vld = 1'b1;
        win     = M_P;
        if      (sel_deb[0]) win = M_P;
        else if (sel_deb[1]) win = M_N;
        else if (sel_deb[2]) win = M_R;
        else if (sel_deb[3]) win = M_D;
        else                 win_vld = 1'b0;
    end

    // "no selection" is a distinct value, so releasing and re-pressing counts as a change
    assign pend = {win_vld, win} != sel_last_q;

    always_comb begin
        up_thr = T34;
        in_thr = T34;
        case (gear_q)
            2'd0:    begin up_thr = T12; in_thr = T12; end
            2'd1:    begin up_thr = T23; in_thr = T12; end
            2'd2:    begin up_thr = T34; in_thr = T23; end
            default: begin up_thr = T34; in_thr = T34; end
        endcase
    end

    always_comb begin
        up_ok = (gear_q != 2'd3) && (speed_i >= up_thr);
        dn_ok = (gear_q != 2'd0) && (speed_i < in_thr - SPEED_W'(HYST));
`ifdef KICKDOWN_EN
        if (kickdown_i) begin
            up_ok = 1'b0;
            if (gear_q != 2'd0 && speed_i < in_thr) dn_ok = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        gear_d     = gear_q;
        act_mode_d = act_mode_q;
        act_gear_d = act_gear_q;
        act_req_d  = act_req_q;
        reject_d   = 1'b0;
        fault_d    = fault_q;
        sel_last_d = sel_last_q;
        wcnt_d     = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (pend) begin
                    sel_last_d = {win_vld, win};
                    if (win_vld && win != mode_q) begin
                        if ((mode_q == M_P && !brake_i) ||
                            ((win == M_P || win == M_R) && speed_i != '0)) begin
                            reject_d = 1'b1;
                        end else begin
                            act_mode_d = win;
                            act_gear_d = 2'd0;
                            state_d    = S_REQ;
                        end
                    end
                end else if (mode_q == M_D && (up_ok || dn_ok)) begin
                    act_mode_d = M_D;
                    act_gear_d = dn_ok ? gear_q - 2'd1 : gear_q + 2'd1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                act_req_d = 1'b1;
                wcnt_d    = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (act_ack_i) begin
                    mode_d    = act_mode_q;
                    gear_d    = act_gear_q;
                    act_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (wcnt_q == WCW'(SHIFT_CYC - 1)) begin
                    act_req_d = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = S_FAULT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            mode_q     <= M_P;
            gear_q     <= 2'd0;
            act_mode_q <= M_P;
            act_gear_q <= 2'd0;
            act_req_q  <= 1'b0;
            reject_q   <= 1'b0;
            fault_q    <= 1'b0;
            sel_last_q <= {1'b1, M_P};
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            gear_q     <= gear_d;
            act_mode_q <= act_mode_d;
            act_gear_q <= act_gear_d;
            act_req_q  <= act_req_d;
            reject_q   <= reject_d;
            fault_q    <= fault_d;
            sel_last_q <= sel_last_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign act_req_o  = act_req_q;
    assign act_mode_o = act_mode_q;
    assign act_gear_o = act_gear_q;
    assign mode_o     = mode_q;
    assign gear_o     = gear_q;
    assign busy_o     = act_req_q;
    assign reject_o   = reject_q;
    assign fault_o    = fault_q;
endmodule

// File: tb/tb_shift_scheduler.sv
// Directed + randomized bench for shift_scheduler; gear expectations come from a
// threshold/hysteresis model of the shift rules. Kickdown steps run when KICKDOWN_EN is set.

module tb_shift_scheduler;
    localparam int DEB = 4, SHIFT = 255, HYST = 5;

    logic       clk = 1'b0;
    logic       reset, p, n, r, d, brake, ack, kick;
    logic [7:0] speed;
    logic       act_req_o, busy_o, reject_o, fault_o;
    logic [1:0] act_mode_o, act_gear_o, mode_o, gear_o;

    int checks = 0, errors = 0;
    int ref_gear = 0, spd = 0;
    int chg_at[$];
    int lat, rj, rq, cnt;

    shift_scheduler dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .p_i        (p),
        .n_i        (n),
        .r_i        (r),
        .d_i        (d),
        .brake_i    (brake),
        .speed_i    (speed),
`ifdef KICKDOWN_EN
        .kickdown_i (kick),
`endif
        .act_ack_i  (ack),
        .act_req_o  (act_req_o),
        .act_mode_o (act_mode_o),
        .act_gear_o (act_gear_o),
        .mode_o     (mode_o),
        .gear_o     (gear_o),
        .busy_o     (busy_o),
        .reject_o   (reject_o),
        .fault_o    (fault_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int up_thr(input int g);
        case (g)
            0: return 20;
            1: return 40;
            default: return 60;
        endcase
    endfunction

    // One shift decision: upshift at the threshold out of g, downshift below the threshold into g minus HYST
    function automatic int step(input int g, input int s);
        if (g < 3 && s >= up_thr(g)) return g + 1;
        if (g > 0 && s < up_thr(g - 1) - HYST) return g - 1;
        return g;
    endfunction

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic watch(input int ncyc, output int rej, output int req);
        rej = 0;
        req = 0;
        repeat (ncyc) begin
            tick();
            if (reject_o) rej++;
            if (act_req_o) req++;
        end
    endtask

    task automatic wait_req(input int maxc, output int l);
        l = -1;
        for (int c = 1; c <= maxc; c++) begin
            tick();
            if (act_req_o) begin
                l = c;
                break;
            end
        end
    endtask

    // Service gear handshakes in D until the design stays quiet for four cycles
    task automatic settle();
        int quiet = 0;
        int nc = 0;
        int eg;
        while (quiet < 4 && nc < 200) begin
            tick();
            nc++;
            if (act_req_o) begin
                eg = step(ref_gear, spd);
                check("gear_req_mode", act_mode_o, 3);
                check("gear_req_gear", act_gear_o, eg);
                ack_pulse();
                if (eg != ref_gear) chg_at.push_back(spd);
                ref_gear = eg;
                check("gear_after_ack", gear_o, ref_gear);
                quiet = 0;
            end else begin
                quiet++;
            end
        end
        check("settle_quiet", quiet, 4);
        check("settled_gear", gear_o, ref_gear);
    endtask

    initial begin
        reset = 1'b1; p = 0; n = 0; r = 0; d = 0; brake = 0; ack = 0; kick = 0; speed = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_mode", mode_o, 0);
        check("rst_gear", gear_o, 0);
        check("rst_act_req", act_req_o, 0);
        check("rst_act_mode", act_mode_o, 0);
        check("rst_act_gear", act_gear_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_reject", reject_o, 0);
        check("rst_fault", fault_o, 0);
        watch(20, rj, rq);
        check("idle_req", rq, 0);
        check("idle_mode", mode_o, 0);
        check("idle_fault", fault_o, 0);

        // N without brake is refused
        n = 1;
        watch(12, rj, rq);
        check("n_nobrake_reject", rj, 1);
        check("n_nobrake_req", rq, 0);
        check("n_nobrake_mode", mode_o, 0);

        // Release, then a fresh N with brake goes through
        n = 0;
        watch(8, rj, rq);
        brake = 1;
        n = 1;
        wait_req(20, lat);
        check("n_latency", lat, DEB + 2);
        check("n_act_mode", act_mode_o, 1);
        check("n_busy", busy_o, 1);
        ack_pulse();
        check("n_mode", mode_o, 1);
        check("n_req_drop", act_req_o, 0);
        check("n_busy_drop", busy_o, 0);

        // N -> D
        n = 0;
        d = 1;
        wait_req(20, lat);
        check("d_latency", lat, DEB + 2);
        check("d_act_mode", act_mode_o, 3);
        check("d_act_gear", act_gear_o, 0);
        ack_pulse();
        check("d_mode", mode_o, 3);
        check("d_gear", gear_o, 0);

        // Ramps by 1 km/h: gear changes land exactly on the thresholds
        chg_at.delete();
        for (int s = 0; s <= 65; s++) begin
            spd = s;
            speed = 8'(s);
            settle();
        end
        check("up_count", chg_at.size(), 3);
        if (chg_at.size() == 3) begin
            check("up_at_20", chg_at[0], 20);
            check("up_at_40", chg_at[1], 40);
            check("up_at_60", chg_at[2], 60);
        end
        check("top_gear", gear_o, 3);
        chg_at.delete();
        for (int s = 65; s >= 0; s--) begin
            spd = s;
            speed = 8'(s);
            settle();
        end
        check("dn_count", chg_at.size(), 3);
        if (chg_at.size() == 3) begin
            check("dn_at_54", chg_at[0], 54);
            check("dn_at_34", chg_at[1], 34);
            check("dn_at_14", chg_at[2], 14);
        end
        check("floor_gear", gear_o, 0);

        // Random speed jumps, possibly several shifts per jump
        for (int i = 0; i < 30; i++) begin
            spd = int'($urandom_range(0, 80));
            speed = 8'(spd);
            settle();
        end
        check("rand_mode", mode_o, 3);

`ifdef KICKDOWN_EN
        spd = 40; speed = 8'(spd); settle();
        spd = 38; speed = 8'(spd); settle();
        check("kd_pre_gear", gear_o, 2);
        kick = 1;
        wait_req(10, lat);
        check("kd_req_seen", (lat > 0) ? 1 : 0, 1);
        check("kd_act_gear", act_gear_o, 1);
        ack_pulse();
        ref_gear = 1;
        check("kd_gear", gear_o, 1);
        spd = 45; speed = 8'(spd);
        watch(12, rj, rq);
        check("kd_no_upshift", rq, 0);
        kick = 0;
        settle();
        check("kd_release_gear", gear_o, 2);
`endif

        // R at speed is refused
        spd = 30; speed = 8'(spd); settle();
        r = 1;
        watch(12, rj, rq);
        check("r_moving_reject", rj, 1);
        check("r_moving_req", rq, 0);
        check("r_moving_mode", mode_o, 3);

        // Stopping alone does not retry R; only downshifts happen
        spd = 0; speed = '0; settle();
        check("stop_mode", mode_o, 3);
        check("stop_gear", gear_o, 0);
        r = 0;
        watch(10, rj, rq);
        check("r_release_req", rq, 0);
        r = 1;
        wait_req(20, lat);
        check("r_latency", lat, DEB + 2);
        check("r_act_mode", act_mode_o, 2);
        check("r_act_gear", act_gear_o, 0);
        ack_pulse();
        check("r_mode", mode_o, 2);
        check("r_gear", gear_o, 0);

        // Short glitch never debounces
        p = 1;
        repeat (DEB - 1) tick();
        p = 0;
        watch(12, rj, rq);
        check("glitch_req", rq, 0);
        check("glitch_reject", rj, 0);
        check("glitch_mode", mode_o, 2);

        // Withheld ack -> timeout fault
        r = 0; d = 0; n = 1;
        wait_req(20, lat);
        check("to_latency", lat, DEB + 2);
        cnt = (lat > 0) ? 1 : 0;
        for (int c = 0; c < 400 && !fault_o; c++) begin
            tick();
            if (act_req_o) cnt++;
        end
        check("to_req_cycles", cnt, SHIFT);
        check("to_fault", fault_o, 1);
        check("to_req_low", act_req_o, 0);
        check("to_busy_low", busy_o, 0);
        check("to_mode", mode_o, 2);
        ack_pulse();
        n = 0; d = 1;
        watch(12, rj, rq);
        check("fault_ignores_req", rq, 0);
        check("fault_mode_hold", mode_o, 2);
        check("fault_held", fault_o, 1);

        // Reset clears fault; then abort a fresh handshake with reset
        d = 0; n = 1;
        reset = 1; tick(); reset = 0;
        check("post_rst_fault", fault_o, 0);
        check("post_rst_mode", mode_o, 0);
        wait_req(20, lat);
        check("abort_req_seen", (lat > 0) ? 1 : 0, 1);
        reset = 1; tick(); reset = 0;
        check("abort_act_req", act_req_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_act_mode", act_mode_o, 0);
        check("abort_mode", mode_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
